// File: rtl/matrixmult_mac_pipe.sv
// Multiply pipeline with per-beat signed/unsigned mode, followed by a dot-product
// accumulator that closes on in_last and reports sum, saturating count and sticky overflow.
module matrixmult_mac_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 13,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce,
    input  logic                             in_valid,
    input  logic                             in_first,
    input  logic                             in_last,
    input  logic                             is_signed,
    input  logic [DIN0_WIDTH-1:0]            din0,
    input  logic [DIN1_WIDTH-1:0]            din1,
    output logic                             prod_valid,
    output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] prod_dout,
    output logic                             out_valid,
    output logic [ACC_WIDTH-1:0]             dout,
    output logic                             out_ovf,
    output logic [CNT_WIDTH-1:0]             out_count
);
    localparam int P = DIN0_WIDTH + DIN1_WIDTH;

    logic signed [P:0]     a_ext, b_ext;
    logic [P-1:0]          mult_p;

    logic [P-1:0]          prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]  vld_q, first_q, last_q, sgn_q;

    logic [ACC_WIDTH-1:0]  acc_q, acc_d, ext;
    logic [ACC_WIDTH:0]    sum;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, add_ovf, open_q, start;
    logic                  out_valid_q, out_ovf_q;
    logic [ACC_WIDTH-1:0]  dout_q;
    logic [CNT_WIDTH-1:0]  out_count_q;

    logic                  p_vld, p_first, p_last, p_sgn;
    logic [P-1:0]          p_prod;

    // Operands widened to P+1 bits so the low P product bits are right in either mode.
    always_comb begin
        a_ext  = is_signed ? (P+1)'($signed(din0)) : (P+1)'(din0);
        b_ext  = is_signed ? (P+1)'($signed(din1)) : (P+1)'(din1);
        mult_p = P'(a_ext * b_ext);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            sgn_q   <= '0;
        end else if (ce) begin
            prod_q[0]  <= mult_p;
            vld_q[0]   <= in_valid;
            first_q[0] <= in_first;
            last_q[0]  <= in_last;
            sgn_q[0]   <= is_signed;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i]  <= prod_q[i-1];
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                sgn_q[i]   <= sgn_q[i-1];
            end
        end
    end

    assign p_vld   = vld_q[NUM_STAGE-1];
    assign p_first = first_q[NUM_STAGE-1];
    assign p_last  = last_q[NUM_STAGE-1];
    assign p_sgn   = sgn_q[NUM_STAGE-1];
    assign p_prod  = prod_q[NUM_STAGE-1];

    // A vector also opens implicitly when no vector is in progress.
    always_comb begin
        ext     = p_sgn ? ACC_WIDTH'($signed(p_prod)) : ACC_WIDTH'(p_prod);
        sum     = {1'b0, acc_q} + {1'b0, ext};
        add_ovf = p_sgn ? ((acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                           (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                        : sum[ACC_WIDTH];
        start   = p_first | ~open_q;
        acc_d   = ext;
        cnt_d   = CNT_WIDTH'(1);
        ovf_d   = 1'b0;
        if (!start) begin
            acc_d = sum[ACC_WIDTH-1:0];
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
            ovf_d = ovf_q | add_ovf;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            open_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
        end else if (ce) begin
            out_valid_q <= p_vld & p_last;
            if (p_vld) begin
                acc_q  <= acc_d;
                cnt_q  <= cnt_d;
                ovf_q  <= ovf_d;
                open_q <= ~p_last;
                if (p_last) begin
                    dout_q      <= acc_d;
                    out_ovf_q   <= ovf_d;
                    out_count_q <= cnt_d;
                end
            end
        end
    end

    assign prod_valid = p_vld;
    assign prod_dout  = p_prod;
    assign out_valid  = out_valid_q;
    assign dout       = dout_q;
    assign out_ovf    = out_ovf_q;
    assign out_count  = out_count_q;
endmodule

// File: tb/tb_matrixmult_mac_pipe.sv
// Directed bench: default instance plus a 29-bit-accumulator instance sharing the same stimulus.
module tb_matrixmult_mac_pipe;
    logic        clk = 1'b0;
    logic        reset, ce, in_valid, in_first, in_last, is_signed;
    logic [15:0] din0;
    logic [12:0] din1;

    logic        prod_valid, out_valid, out_ovf;
    logic [28:0] prod_dout;
    logic [39:0] dout;
    logic [15:0] out_count;

    logic        o_prod_valid, o_out_valid, o_out_ovf;
    logic [28:0] o_prod_dout;
    logic [28:0] o_dout;
    logic [15:0] o_out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrixmult_mac_pipe dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .is_signed(is_signed), .din0(din0), .din1(din1),
        .prod_valid(prod_valid), .prod_dout(prod_dout), .out_valid(out_valid),
        .dout(dout), .out_ovf(out_ovf), .out_count(out_count)
    );

    matrixmult_mac_pipe #(.ACC_WIDTH(29)) dut_ovf (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .is_signed(is_signed), .din0(din0), .din1(din1),
        .prod_valid(o_prod_valid), .prod_dout(o_prod_dout), .out_valid(o_out_valid),
        .dout(o_dout), .out_ovf(o_out_ovf), .out_count(o_out_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic f, input logic l, input logic s,
                        input logic [15:0] a, input logic [12:0] b);
        in_valid  = 1'b1;
        in_first  = f;
        in_last   = l;
        is_signed = s;
        din0      = a;
        din1      = b;
        step();
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        is_signed = 1'b0; din0 = '0; din1 = '0;
        step(); step();
        checks++; if (prod_valid !== 1'b0) begin errors++; $display("FAIL reset_prod_valid got %0b exp 0", prod_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (dout !== 40'd0) begin errors++; $display("FAIL reset_dout got %0h exp 0", dout); end
        checks++; if (out_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", out_count); end
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_unsigned();
        beat(1'b1, 1'b0, 1'b0, 16'hFFFF, 13'h1FFF);
        beat(1'b0, 1'b0, 1'b0, 16'd2, 13'd3);
        checks++; if (prod_valid !== 1'b1) begin errors++; $display("FAIL uns_prod_valid got %0b exp 1", prod_valid); end
        checks++; if (prod_dout !== 29'd536797185) begin errors++; $display("FAIL uns_prod_dout got %0d exp 536797185", prod_dout); end
        beat(1'b0, 1'b1, 1'b0, 16'd10, 13'd10);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uns_early_valid got %0b exp 0", out_valid); end
        step();
        $display("unsigned vector: valid=%0b dout=%0d count=%0d ovf=%0b", out_valid, dout, out_count, out_ovf);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL uns_out_valid got %0b exp 1", out_valid); end
        checks++; if (dout !== 40'd536797291) begin errors++; $display("FAIL uns_dout got %0d exp 536797291", dout); end
        checks++; if (out_count !== 16'd3) begin errors++; $display("FAIL uns_count got %0d exp 3", out_count); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL uns_ovf got %0b exp 0", out_ovf); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uns_pulse_end got %0b exp 0", out_valid); end
        checks++; if (dout !== 40'd536797291) begin errors++; $display("FAIL uns_dout_hold got %0d exp 536797291", dout); end
    endtask

    task automatic test_reset_mid();
        beat(1'b1, 1'b0, 1'b0, 16'd9, 13'd9);
        beat(1'b0, 1'b0, 1'b0, 16'd9, 13'd9);
        reset = 1'b1;
        #1;
        checks++; if (prod_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_prod_valid got %0b exp 0", prod_valid); end
        checks++; if (prod_dout !== 29'd0) begin errors++; $display("FAIL mid_rst_prod_dout got %0d exp 0", prod_dout); end
        checks++; if (dout !== 40'd0) begin errors++; $display("FAIL mid_rst_dout got %0d exp 0", dout); end
        checks++; if (out_count !== 16'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", out_count); end
        step();
        reset = 1'b0;
        beat(1'b0, 1'b1, 1'b0, 16'd3, 13'd4);
        step(); step();
        $display("post-reset vector: valid=%0b dout=%0d count=%0d", out_valid, dout, out_count);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_out_valid got %0b exp 1", out_valid); end
        checks++; if (dout !== 40'd12) begin errors++; $display("FAIL mid_rst_vec_dout got %0d exp 12", dout); end
        checks++; if (out_count !== 16'd1) begin errors++; $display("FAIL mid_rst_vec_count got %0d exp 1", out_count); end
    endtask

    task automatic test_signed();
        beat(1'b1, 1'b0, 1'b1, 16'hFFFF, 13'd5);
        beat(1'b0, 1'b1, 1'b1, 16'h0003, 13'h1FFE);
        checks++; if (prod_dout !== 29'h1FFFFFFB) begin errors++; $display("FAIL sgn_prod_dout got %0h exp 1ffffffb", prod_dout); end
        step(); step();
        $display("signed vector: valid=%0b dout=%0h count=%0d ovf=%0b", out_valid, dout, out_count, out_ovf);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sgn_out_valid got %0b exp 1", out_valid); end
        checks++; if (dout !== 40'hFFFFFFFFF5) begin errors++; $display("FAIL sgn_dout got %0h exp fffffffff5", dout); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL sgn_ovf got %0b exp 0", out_ovf); end
    endtask

    task automatic test_overflow();
        beat(1'b1, 1'b0, 1'b0, 16'hFFFF, 13'h1FFF);
        beat(1'b0, 1'b1, 1'b0, 16'hFFFF, 13'h1FFF);
        step(); step();
        $display("overflow vector: acc29 dout=%0d ovf=%0b acc40 dout=%0d ovf=%0b", o_dout, o_out_ovf, dout, out_ovf);
        checks++; if (o_dout !== 29'd536723458) begin errors++; $display("FAIL ovf_dout got %0d exp 536723458", o_dout); end
        checks++; if (o_out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", o_out_ovf); end
        checks++; if (o_out_count !== 16'd2) begin errors++; $display("FAIL ovf_count got %0d exp 2", o_out_count); end
        checks++; if (dout !== 40'd1073594370) begin errors++; $display("FAIL ovf_wide_dout got %0d exp 1073594370", dout); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_wide_flag got %0b exp 0", out_ovf); end
        beat(1'b1, 1'b1, 1'b0, 16'd1, 13'd1);
        step(); step();
        $display("post-overflow vector: acc29 dout=%0d ovf=%0b", o_dout, o_out_ovf);
        checks++; if (o_out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", o_out_ovf); end
        checks++; if (o_dout !== 29'd1) begin errors++; $display("FAIL ovf_next_dout got %0d exp 1", o_dout); end
    endtask

    task automatic test_gap();
        beat(1'b1, 1'b0, 1'b0, 16'd2, 13'd3);
        step();
        beat(1'b0, 1'b1, 1'b0, 16'd4, 13'd5);
        step(); step();
        $display("gapped vector: valid=%0b dout=%0d count=%0d", out_valid, dout, out_count);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_out_valid got %0b exp 1", out_valid); end
        checks++; if (dout !== 40'd26) begin errors++; $display("FAIL gap_dout got %0d exp 26", dout); end
        checks++; if (out_count !== 16'd2) begin errors++; $display("FAIL gap_count got %0d exp 2", out_count); end
    endtask

    task automatic test_ce_stall();
        beat(1'b1, 1'b1, 1'b0, 16'd7, 13'd7);
        beat(1'b1, 1'b0, 1'b0, 16'd2, 13'd3);
        beat(1'b0, 1'b1, 1'b0, 16'd10, 13'd10);
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_hold[%0d] got %0b exp 1", i, out_valid); end
            checks++; if (dout !== 40'd49) begin errors++; $display("FAIL stall_dout_hold[%0d] got %0d exp 49", i, dout); end
            checks++; if (prod_dout !== 29'd6) begin errors++; $display("FAIL stall_prod_hold[%0d] got %0d exp 6", i, prod_dout); end
            step();
        end
        ce = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_gap_valid got %0b exp 0", out_valid); end
        step();
        $display("stalled vector: valid=%0b dout=%0d count=%0d", out_valid, dout, out_count);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid got %0b exp 1", out_valid); end
        checks++; if (dout !== 40'd106) begin errors++; $display("FAIL stall_dout got %0d exp 106", dout); end
        checks++; if (out_count !== 16'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", out_count); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] exp_d [3];
        exp_d[0] = 40'd4; exp_d[1] = 40'd9; exp_d[2] = 40'd16;
        beat(1'b1, 1'b1, 1'b0, 16'd2, 13'd2);
        beat(1'b1, 1'b1, 1'b0, 16'd3, 13'd3);
        beat(1'b1, 1'b1, 1'b0, 16'd4, 13'd4);
        for (int i = 0; i < 3; i++) begin
            $display("b2b vector %0d: valid=%0b dout=%0d count=%0d", i, out_valid, dout, out_count);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %0b exp 1", i, out_valid); end
            checks++; if (dout !== exp_d[i]) begin errors++; $display("FAIL b2b_dout[%0d] got %0d exp %0d", i, dout, exp_d[i]); end
            checks++; if (out_count !== 16'd1) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 1", i, out_count); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %0b exp 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_reset_mid();
        test_signed();
        test_overflow();
        test_gap();
        test_ce_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
